// File: rtl/vram_pkg.sv
// Shared types, default widths and helpers for the VRAM port arbiter.
package vram_pkg;

   localparam int unsigned AW_DEF    = 16;
   localparam int unsigned DW_DEF    = 16;
   localparam int unsigned RD_LAT    = 1;   // RAM clocks from read strobe to valid ram_rdata
   localparam int unsigned BEAT_W    = 8;
   localparam int unsigned WIN_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   // Tie goes to the port that did not own the RAM last.
   function automatic arb_state_e arb_pick(input logic r0, input logic r1, input logic last);
      arb_state_e s;
      s = IDLE;
      if (r0 && r1) begin
         s = last ? OWN0 : OWN1;
      end else if (r0) begin
         s = OWN0;
      end else if (r1) begin
         s = OWN1;
      end
      return s;
   endfunction

endpackage

// File: rtl/vram_win_timer.sv
// Post-frame write window: loads on every frame pulse and counts down to zero;
// the window is open while the count is non-zero.
module vram_win_timer
   import vram_pkg::*;
#(
   parameter int unsigned WIN_CYCLES = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_i,
   output logic open_o
);

   logic [WIN_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (frame_i) begin
         cnt_d = WIN_CNT_W'(WIN_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - WIN_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign open_o = (cnt_q != '0);

endmodule

// File: rtl/vram_arbiter.sv
// Round-robin VRAM port arbiter between the frame engine (port 0) and the UART loader (port 1).
// Optional VRAM_VBLANK_ONLY_EN limits port-1 writes to a window after each frame pulse.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned AW         = AW_DEF,
   parameter int unsigned DW         = DW_DEF,
   parameter int unsigned BURST_MAX  = 8,
   parameter int unsigned WIN_CYCLES = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic          ram_ce,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   input  logic          frame_int,
   output logic          busy
);

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

   arb_state_e        state_q, state_d;
   logic              last_q, last_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [RD_LAT-1:0] rpend_q, rpend_d;
   logic [RD_LAT-1:0] rsel_q, rsel_d;
   logic              rvalid0_q, rvalid1_q;
   logic [DW-1:0]     rdata0_q, rdata1_q;
   logic              req1_eff;
   logic              re_arb;
   logic              rd_acc;
   logic              rd_ret;
   logic              rd_ret_p1;

`ifdef VRAM_VBLANK_ONLY_EN
   logic win_open;

   vram_win_timer #(
      .WIN_CYCLES (WIN_CYCLES)
   ) u_win_timer (
      .clk     (clk),
      .rst_n   (reset),
      .frame_i (frame_int),
      .open_o  (win_open)
   );

   // A port-1 write outside the window is invisible to arbitration.
   assign req1_eff = req1 & (~we1 | win_open);
`else
   logic                 unused_frame;
   logic [WIN_CNT_W-1:0] unused_win;

   assign unused_frame = frame_int;
   assign unused_win   = WIN_CNT_W'(WIN_CYCLES);
   assign req1_eff     = req1;
`endif

   // Next-state, burst counting and RAM port mux.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      beat_d    = beat_q;
      re_arb    = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;

      case (state_q)
         OWN0: begin
            gnt0      = req0;
            ram_we    = req0 & we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
            if (!req0 || (beat_q == BEAT_LAST)) begin
               re_arb = 1'b1;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         OWN1: begin
            gnt1      = req1_eff;
            ram_we    = req1_eff & we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
            if (!req1_eff || (beat_q == BEAT_LAST)) begin
               re_arb = 1'b1;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         default: begin
            re_arb = 1'b1;
         end
      endcase

      // last_q already names the current owner, so the other port wins a tie.
      if (re_arb) begin
         beat_d  = '0;
         state_d = arb_pick(req0, req1_eff, last_q);
         if (state_d == OWN0) begin
            last_d = 1'b0;
         end else if (state_d == OWN1) begin
            last_d = 1'b1;
         end
      end

      ram_ce = gnt0 | gnt1;
      rd_acc = ram_ce & ~ram_we;
   end

   // Read-return pipeline: owner tag travels alongside the pending flag.
   assign rpend_d   = RD_LAT'({rpend_q, rd_acc});
   assign rsel_d    = RD_LAT'({rsel_q, (state_q == OWN1)});
   assign rd_ret    = rpend_q[RD_LAT-1] & ~rsel_q[RD_LAT-1];
   assign rd_ret_p1 = rpend_q[RD_LAT-1] &  rsel_q[RD_LAT-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         beat_q    <= '0;
         rpend_q   <= '0;
         rsel_q    <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         beat_q    <= beat_d;
         rpend_q   <= rpend_d;
         rsel_q    <= rsel_d;
         rvalid0_q <= rd_ret;
         rvalid1_q <= rd_ret_p1;
         if (rd_ret) begin
            rdata0_q <= ram_rdata;
         end
         if (rd_ret_p1) begin
            rdata1_q <= ram_rdata;
         end
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, single write, read latency, tie-break,
// burst limit, back-to-back bursts and the port-1 write window option.
module tb_vram_arbiter;

   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 16;
   localparam int unsigned BM  = 8;
   localparam int unsigned WIN = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, we0, req1, we1, frame_int;
   logic [AW-1:0] addr0, addr1, ram_addr;
   logic [DW-1:0] wdata0, wdata1, ram_wdata, ram_rdata;
   logic          gnt0, gnt1, rvalid0, rvalid1, ram_ce, ram_we, busy;
   logic [DW-1:0] rdata0, rdata1;

   logic [DW-1:0] mem [0:1023];
   int            checks   = 0;
   int            failures = 0;
   int            cyc;

   always #5 clk = ~clk;

   vram_arbiter #(
      .AW(AW), .DW(DW), .BURST_MAX(BM), .WIN_CYCLES(WIN)
   ) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .frame_int(frame_int), .busy(busy)
   );

   // RAM model: one-clock read latency; 0x0123 preset to 0xBEEF while in reset.
   always @(posedge clk) begin
      if (!reset) begin
         mem[10'h123] <= 16'hBEEF;
      end else if (ram_ce) begin
         if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr[9:0]];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      frame_int = 1'b0;
   endtask

   function automatic logic [1:0] exp_tie(input int c);
      if (c == 0) return 2'b00;
      return ((((c - 1) / int'(BM)) % 2) == 0) ? 2'b10 : 2'b01;
   endfunction

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      tick(); tick(); #1;
      checks++;
      if ({busy, gnt0, gnt1, ram_ce, ram_we} !== 5'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, gnt0, gnt1, ram_ce, ram_we});
      end
      checks++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
         failures++; $display("FAIL reset_rvalid got=%b exp=00", {rvalid0, rvalid1});
      end
      checks++;
      if ({ram_addr, ram_wdata} !== 32'h0) begin
         failures++; $display("FAIL reset_ram_bus got=%h exp=0", {ram_addr, ram_wdata});
      end
      checks++;
      if ({rdata0, rdata1} !== 32'h0) begin
         failures++; $display("FAIL reset_rdata got=%h exp=0", {rdata0, rdata1});
      end
      reset = 1'b1;
      tick(); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL reset_release_busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_single_write();
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hF800;
      #1;
      checks++;
      if ({busy, gnt0, ram_ce} !== 3'b000) begin
         failures++; $display("FAIL wr_idle_cycle got=%b exp=000", {busy, gnt0, ram_ce});
      end
      tick(); #1;
      checks++;
      if ({busy, gnt0, gnt1, ram_ce, ram_we} !== 5'b11011) begin
         failures++; $display("FAIL wr_accept_ctrl got=%b exp=11011", {busy, gnt0, gnt1, ram_ce, ram_we});
      end
      checks++;
      if ({ram_addr, ram_wdata} !== {16'h0010, 16'hF800}) begin
         failures++; $display("FAIL wr_accept_bus got=%h exp=0010f800", {ram_addr, ram_wdata});
      end
      tick();
      req0 = 1'b0; we0 = 1'b0;
      #1;
      checks++;
      if ({gnt0, ram_ce, ram_we} !== 3'b000) begin
         failures++; $display("FAIL wr_after_drop got=%b exp=000", {gnt0, ram_ce, ram_we});
      end
      tick(); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL wr_back_idle got=%b exp=0", busy);
      end
      checks++;
      if (mem[10'h010] !== 16'hF800) begin
         failures++; $display("FAIL wr_mem_data got=%h exp=f800", mem[10'h010]);
      end
   endtask

   task automatic test_read_latency();
      int gcyc, vcyc, n0, n1;
      logic [DW-1:0] vdata;
      logic [AW-1:0] gaddr;
      logic          gwe;
      gcyc = -1; vcyc = -1; n0 = 0; n1 = 0; vdata = '0; gaddr = '0; gwe = 1'b1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0123;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (gnt1 && gcyc < 0) begin
            gcyc = c; gaddr = ram_addr; gwe = ram_we;
         end
         if (rvalid1) begin
            n1++;
            if (vcyc < 0) begin
               vcyc = c; vdata = rdata1;
            end
         end
         if (rvalid0) n0++;
         tick();
         if (gcyc >= 0) req1 = 1'b0;
      end
      checks++;
      if (gcyc < 0 || vcyc < 0 || (vcyc - gcyc) !== 2) begin
         failures++; $display("FAIL rd_latency got=%0d exp=2 (gnt@%0d rvalid@%0d)", vcyc - gcyc, gcyc, vcyc);
      end
      checks++;
      if ({gaddr, gwe} !== {16'h0123, 1'b0}) begin
         failures++; $display("FAIL rd_ram_bus got=%h/%b exp=0123/0", gaddr, gwe);
      end
      checks++;
      if (vdata !== 16'hBEEF) begin
         failures++; $display("FAIL rd_data got=%h exp=beef", vdata);
      end
      checks++;
      if (n1 !== 1 || n0 !== 0) begin
         failures++; $display("FAIL rd_valid_counts got=%0d/%0d exp=1/0", n1, n0);
      end
   endtask

   task automatic test_reset_mid_read();
      int n0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0123;
      tick(); #1;
      checks++;
      if (gnt0 !== 1'b1) begin
         failures++; $display("FAIL mid_rd_accept got=%b exp=1", gnt0);
      end
      tick();
      req0 = 1'b0; reset = 1'b0;
      tick(); #1;
      checks++;
      if ({rvalid0, busy, gnt0, gnt1, ram_ce, ram_we} !== 6'b0) begin
         failures++; $display("FAIL mid_rd_reset_state got=%b exp=000000", {rvalid0, busy, gnt0, gnt1, ram_ce, ram_we});
      end
      reset = 1'b1;
      n0 = 0;
      for (int c = 0; c < 4; c++) begin
         tick(); #1;
         if (rvalid0) n0++;
      end
      checks++;
      if (n0 !== 0) begin
         failures++; $display("FAIL mid_rd_dropped got=%0d exp=0", n0);
      end
   endtask

   task automatic test_tie();
      reset = 1'b0;
      clear_inputs();
      tick(); tick();
      reset = 1'b1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0200; wdata0 = 16'h1111;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0300;
      for (cyc = 0; cyc < 10; cyc++) begin
         #1;
         checks++;
         if ({gnt0, gnt1} !== exp_tie(cyc)) begin
            failures++; $display("FAIL tie_grant c=%0d got=%b exp=%b", cyc, {gnt0, gnt1}, exp_tie(cyc));
         end
         tick();
      end
   endtask

   task automatic test_burst_limit();
      for (; cyc < 34; cyc++) begin
         #1;
         checks++;
         if ({gnt0, gnt1, ram_ce} !== {exp_tie(cyc), 1'b1}) begin
            failures++; $display("FAIL burst_grant c=%0d got=%b exp=%b", cyc, {gnt0, gnt1, ram_ce}, {exp_tie(cyc), 1'b1});
         end
         if (cyc % 8 == 1) begin
            checks++;
            if (ram_addr !== (exp_tie(cyc) == 2'b10 ? 16'h0200 : 16'h0300)) begin
               failures++; $display("FAIL burst_addr c=%0d got=%h", cyc, ram_addr);
            end
         end
         tick();
      end
      clear_inputs();
      tick(); tick();
   endtask

   task automatic test_drop_before_grant();
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h1234;
      tick();
      req0 = 1'b0;
      #1;
      checks++;
      if ({gnt0, ram_ce} !== 2'b00) begin
         failures++; $display("FAIL drop_no_access got=%b exp=00", {gnt0, ram_ce});
      end
      tick(); #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL drop_back_idle got=%b exp=0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int g1cyc;
      logic expg0;
      g1cyc = -1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0100; wdata0 = 16'h00FF;
      we1 = 1'b0; addr1 = 16'h0123;
      for (int c = 0; c < 25; c++) begin
         req1 = (c >= 12);
         #1;
         expg0 = (c >= 1 && c <= 16);
         checks++;
         if (gnt0 !== expg0) begin
            failures++; $display("FAIL b2b_gnt0 c=%0d got=%b exp=%b", c, gnt0, expg0);
         end
         if (gnt1 && g1cyc < 0) g1cyc = c;
         tick();
      end
      checks++;
      if (g1cyc !== 17) begin
         failures++; $display("FAIL b2b_port1_wait got=%0d exp=17", g1cyc);
      end
      clear_inputs();
      tick(); tick();
   endtask

`ifdef VRAM_VBLANK_ONLY_EN
   task automatic test_vblank();
      int n, lo, hi;
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0040; wdata1 = 16'h07E0;
      n = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (gnt1) n++;
         tick();
      end
      checks++;
      if (n !== 0) begin
         failures++; $display("FAIL win_closed_grants got=%0d exp=0", n);
      end
      frame_int = 1'b1;
      #1;
      tick();
      frame_int = 1'b0;
      n = 0; lo = -1; hi = -1;
      for (int c = 1; c < 25; c++) begin
         #1;
         if (gnt1) begin
            n++;
            if (lo < 0) lo = c;
            hi = c;
         end
         tick();
      end
      checks++;
      if ({n, lo, hi} !== {32'd15, 32'd2, 32'd16}) begin
         failures++; $display("FAIL win_grants got=%0d@%0d..%0d exp=15@2..16", n, lo, hi);
      end
      we1 = 1'b0;
      tick(); #1;
      checks++;
      if ({gnt1, ram_we} !== 2'b10) begin
         failures++; $display("FAIL win_read_outside got=%b exp=10", {gnt1, ram_we});
      end
      clear_inputs();
      tick(); tick();
   endtask
`else
   task automatic test_frame_ignored();
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0040; wdata1 = 16'h07E0;
      tick(); #1;
      checks++;
      if ({gnt1, ram_we, ram_wdata} !== {2'b11, 16'h07E0}) begin
         failures++; $display("FAIL p1_write_ungated got=%b/%h exp=11/07e0", {gnt1, ram_we}, ram_wdata);
      end
      frame_int = 1'b1;
      tick();
      frame_int = 1'b0;
      #1;
      checks++;
      if (gnt1 !== 1'b1) begin
         failures++; $display("FAIL p1_frame_ignored got=%b exp=1", gnt1);
      end
      clear_inputs();
      tick(); tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_read_latency();
      test_reset_mid_read();
      test_tie();
      test_burst_limit();
      test_drop_before_grant();
      test_back_to_back();
`ifdef VRAM_VBLANK_ONLY_EN
      test_vblank();
`else
      test_frame_ignored();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single video-RAM port of the LCD controller between two requesters: port 0 (sprite/frame engine) and port 1 (UART loader).
- Round-robin arbitration with bounded bursts.
- Single-cycle RAM access strobes; read data returned one cycle later to the owning requester.
- Sits between the requesters and the LCD controller RAM port (ram_ce etc.), clocked in the RAM clock domain.

Parameters:
- AW, 16, RAM address width.
- DW, 16, RAM data width (RGB565).
- BURST_MAX, 8, max accepted accesses per grant before forced re-arbitration (legal range 1..255).
- WIN_CYCLES, 4096, length of post-frame write window in clocks (only used with VRAM_VBLANK_ONLY_EN).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req0  in  1  port-0 access request, held until granted.
- we0  in  1  port-0 write enable (1 = write, 0 = read).
- addr0  in  AW  port-0 address.
- wdata0  in  DW  port-0 write data.
- gnt0  out  1  port-0 access accepted this cycle.
- rvalid0  out  1  port-0 read data valid.
- rdata0  out  DW  port-0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- ram_ce  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid 1 clk after a read strobe.
- frame_int  in  1  one-clk frame-start pulse, already synchronous to clk.
- busy  out  1  high when state != IDLE.

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, last (last owner), beat (8-bit), rsel, rvalid0/1.
- Reset (reset==0 at a clk edge):
  - state=IDLE, last=1 (port 0 wins first tie), beat=0.
  - rvalid0/1=0, rdata0/1=0.
  - gnt0/1, ram_ce, ram_we, busy all 0; ram_addr/ram_wdata=0.
  - An in-flight read is dropped, and its rvalid is never asserted.
- Grant, combinational from registered state:
  - gnt0 = (state==OWN0) & req0.
  - gnt1 = (state==OWN1) & req1.
  - An access happens exactly in a cycle with req_i & gnt_i.
- RAM port:
  - ram_ce = gnt0|gnt1.
  - ram_we/addr/wdata are muxed from the owner.
  - When ram_ce=0, ram_we=0 and addr/wdata hold the owner's inputs (don't-care).
- Read return:
  - On a read access, rsel <= owner.
  - Next cycle rvalid_rsel=1 with rdata_rsel=ram_rdata (registered); the other port's rvalid stays 0.
  - Fixed read latency: 2 clk from accept to rvalid.
- Arbitration (next-state function pick):
  - If both requests are high, pick the port != last.
  - Otherwise pick whichever is requesting; if none, go to IDLE.
- Transitions:
  - IDLE: pick the next state; beat=0. Entering OWNi sets last=i.
  - OWNi with accepted access: beat+1. If beat==BURST_MAX-1, re-arbitrate in the same edge with the other port preferred (last=i), and clear beat.
  - OWNi with req_i low: re-arbitrate immediately (no bubble if the other port is requesting).
- Boundary and ordering rules:
  - The requester must hold addr/we/wdata stable while req is high and not granted.
  - Dropping req before grant is legal: no access occurs.
  - Back-to-back bursts from the same port are allowed only if the other port is idle at burst end.
  - Worst-case wait for a requester: BURST_MAX+1 clk.
- Width rules: beat saturates logically at BURST_MAX-1 (never wraps past it).

Optional Feature:
- Macro: VRAM_VBLANK_ONLY_EN.
- When defined:
  - A 16-bit window counter loads WIN_CYCLES on frame_int and decrements to 0.
  - Port-1 writes may be granted only while counter != 0.
  - Port-1 reads and all port-0 accesses are unaffected.
  - A gated port-1 write in OWN1 keeps gnt1=0; the arbiter re-arbitrates to port 0 if port 0 is requesting.
  - frame_int while counter != 0 reloads it.
  - Reset clears the counter to 0.
- When undefined: frame_int is ignored and no counter is synthesised.

Decomposition:
- Package vram_pkg holds:
  - The state enum (IDLE/OWN0/OWN1).
  - Default AW/DW constants.
  - The RAM read latency constant (1).
- Natural sub-module: vram_win_timer (window counter for VRAM_VBLANK_ONLY_EN), instantiated only under the macro.

Test Plan:
- Reset mid-read: assert reset one clk after a port-0 read accept -> rvalid0 stays 0, state IDLE, all outputs 0.
- Single write: req0=1, we0=1, addr0=0x0010, wdata0=0xF800 -> state OWN0 next clk; ram_ce=1, ram_we=1, ram_addr=0x0010, ram_wdata=0xF800 for exactly 1 clk when req0 then drops.
- Read latency: port-1 read at addr 0x0123 with RAM model returning 0xBEEF -> rvalid1=1, rdata1=0xBEEF exactly 2 clk after gnt1; rvalid0=0 throughout.
- Tie after reset: req0 and req1 rise together -> port 0 granted first; after its burst ends, port 1 is granted with no idle cycle.
- Burst limit: BURST_MAX=8, both requesting continuously -> grant pattern is 8×gnt0, 8×gnt1, 8×gnt0…; no cycle has both grants; ram_ce high every cycle after the first.
- VRAM_VBLANK_ONLY_EN, WIN_CYCLES=16: port-1 write pending, frame_int pulse -> gnt1 accepted only within 16 clk after the pulse; port-1 reads are granted outside the window.
